// File: rtl/commit_trace_buffer.sv
`timescale 1ns/1ps
// commit_trace_buffer
//
// Captures one record per retired instruction from the writeback stage and
// holds it in a small FIFO until the trace logger takes it. Each stored
// record carries a 16-bit sequence number. If the FIFO is full when a commit
// arrives, that record is lost and the loss is counted. After a HLT
// retires, the buffer stops accepting new commits. It then drains and
// raises done once it is empty.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   commit_*            retiring-instruction fields (valid, pc, inst,
//                       regwrite, wreg, wdata, memread, memwrite, memaddr,
//                       memdata, halt)
//   out_valid/out_ready head-record handshake toward the trace logger
//   out_seq, out_rec    head record (combinational from storage)
//   count               records currently held
//   overflow            sticky flag: at least one record was dropped
//   drop_cnt            number of dropped records, saturating at 255
//   done                halt retired and every record has been consumed
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit_valid,
  input  logic [15:0]   commit_pc,
  input  logic [15:0]   commit_inst,
  input  logic          commit_regwrite,
  input  logic [3:0]    commit_wreg,
  input  logic [15:0]   commit_wdata,
  input  logic          commit_memread,
  input  logic          commit_memwrite,
  input  logic [15:0]   commit_memaddr,
  input  logic [15:0]   commit_memdata,
  input  logic          commit_halt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_seq,
  output logic [87:0]   out_rec,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  output logic          done
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 88;
  localparam int EW = 16 + RW;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   seq_q, seq_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          in_run;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [RW-1:0] rec_in;

  assign rec_in = {commit_pc, commit_inst, commit_regwrite, commit_wreg,
                   commit_wdata, commit_memread, commit_memwrite,
                   commit_memaddr, commit_memdata, commit_halt};

  assign in_run = (state_q == RUN);
  assign full   = (count_q == CW'(DEPTH));
  assign pop    = (count_q != '0) && out_ready;
  // A full buffer still accepts a commit when the head leaves in the same
  // cycle, because the freed slot is reused immediately.
  assign push   = commit_valid && in_run && (!full || pop);
  assign drop   = commit_valid && in_run && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q + CW'(push) - CW'(pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      seq_d    = seq_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // The halt commit moves to DRAIN whether or not it was stored. DRAIN uses
  // the post-pop count, so done rises on the same edge that removes the
  // last record.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (commit_valid && commit_halt) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage has no reset. Slots are only read while count shows
  // they hold valid data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {seq_q, rec_in};
    end
  end

  assign out_valid          = (count_q != '0);
  assign {out_seq, out_rec} = mem_q[rd_ptr_q];
  assign count              = count_q;
  assign overflow           = overflow_q;
  assign drop_cnt           = drop_cnt_q;
  assign done               = (state_q == DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
`timescale 1ns/1ps
// Directed bench for commit_trace_buffer (DEPTH=8).
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          commit_valid;
  logic [15:0]   commit_pc;
  logic [15:0]   commit_inst;
  logic          commit_regwrite;
  logic [3:0]    commit_wreg;
  logic [15:0]   commit_wdata;
  logic          commit_memread;
  logic          commit_memwrite;
  logic [15:0]   commit_memaddr;
  logic [15:0]   commit_memdata;
  logic          commit_halt;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_seq;
  logic [87:0]   out_rec;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          done;

  int total = 0;
  int bad   = 0;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .commit_inst     (commit_inst),
    .commit_regwrite (commit_regwrite),
    .commit_wreg     (commit_wreg),
    .commit_wdata    (commit_wdata),
    .commit_memread  (commit_memread),
    .commit_memwrite (commit_memwrite),
    .commit_memaddr  (commit_memaddr),
    .commit_memdata  (commit_memdata),
    .commit_halt     (commit_halt),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_seq         (out_seq),
    .out_rec         (out_rec),
    .count           (count),
    .overflow        (overflow),
    .drop_cnt        (drop_cnt),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, before inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record fields are derived from the PC so every record differs.
  function automatic logic [87:0] exp_rec(input logic [15:0] pc, input logic halt);
    logic [3:0] wr;
    wr = halt ? 4'd3 : pc[3:0];
    return {pc, pc ^ 16'hC3C3, 1'b1, wr, pc + 16'h1111, pc[2], pc[1],
            ~pc, pc ^ 16'h5A5A, halt};
  endfunction

  task automatic drive(input logic [15:0] pc, input logic halt);
    commit_valid    = 1'b1;
    commit_pc       = pc;
    commit_inst     = pc ^ 16'hC3C3;
    commit_regwrite = 1'b1;
    commit_wreg     = halt ? 4'd3 : pc[3:0];
    commit_wdata    = pc + 16'h1111;
    commit_memread  = pc[2];
    commit_memwrite = pc[1];
    commit_memaddr  = ~pc;
    commit_memdata  = pc ^ 16'h5A5A;
    commit_halt     = halt;
  endtask

  task automatic do_reset();
    commit_valid = 1'b0;
    commit_halt  = 1'b0;
    out_ready    = 1'b0;
    rst          = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(16'h0, 1'b0);
    commit_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    // ---------------- reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_done", done, 0);
    #5 rst = 1'b1;
    tick();

    // ---------------- three commits, consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'(2 * i), 1'b0);
      tick();
      chk($sformatf("basic_valid%0d", i), out_valid, 1);
      chk($sformatf("basic_seq%0d", i), out_seq, i);
      chk($sformatf("basic_rec%0d", i), out_rec, exp_rec(16'(2 * i), 1'b0));
      chk($sformatf("basic_count%0d", i), count, 1);
    end
    commit_valid = 1'b0;
    tick();
    chk("basic_empty_valid", out_valid, 0);
    chk("basic_empty_count", count, 0);
    chk("basic_overflow", overflow, 0);
    tick();
    chk("ready_on_empty_count", count, 0);

    // ---------------- overflow: DEPTH+2 commits with consumer stalled
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(16'h0100 + 16'(2 * i), 1'b0);
      tick();
    end
    commit_valid = 1'b0;
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_cnt", drop_cnt, 2);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_drain_seq%0d", i), out_seq, i);
      chk($sformatf("ovf_drain_rec%0d", i), out_rec, exp_rec(16'h0100 + 16'(2 * i), 1'b0));
      tick();
    end
    chk("ovf_drained_count", count, 0);
    chk("ovf_sticky", overflow, 1);

    // ---------------- full buffer: push with pop, then drop saturation
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(16'h0200 + 16'(2 * i), 1'b0);
      tick();
    end
    chk("full_count", count, DEPTH);
    chk("full_head_seq", out_seq, 8);
    drive(16'h0300, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("fullpp_count", count, DEPTH);
    chk("fullpp_drop_cnt", drop_cnt, 2);
    chk("fullpp_head_seq", out_seq, 9);
    out_ready = 1'b0;
    repeat (260) tick();
    chk("sat_drop_cnt", drop_cnt, 255);
    chk("sat_count", count, DEPTH);
    commit_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("sat_drain_seq%0d", i), out_seq, 9 + i);
      tick();
    end
    chk("sat_drained_count", count, 0);
    out_ready = 1'b0;
    drive(16'h0400, 1'b0);
    tick();
    commit_valid = 1'b0;
    chk("seq_after_drops", out_seq, 17);

    // ---------------- asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(16'h0500 + 16'(2 * i), 1'b0);
      tick();
    end
    commit_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("pre_arst_count", count, 5);
    chk("pre_arst_overflow", overflow, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_done", done, 0);
    #2 rst = 1'b1;
    tick();
    drive(16'h0600, 1'b0);
    tick();
    commit_valid = 1'b0;
    chk("post_arst_seq", out_seq, 0);
    chk("post_arst_count", count, 1);
    chk("post_arst_rec", out_rec, exp_rec(16'h0600, 1'b0));

    // ---------------- sequence number wrap
    do_reset();
    out_ready = 1'b1;
    drive(16'h0010, 1'b0);
    repeat (16'hFFFE) tick();
    chk("wrap_seq_fffd", out_seq, 16'hFFFD);
    tick();
    chk("wrap_seq_fffe", out_seq, 16'hFFFE);
    tick();
    chk("wrap_seq_ffff", out_seq, 16'hFFFF);
    tick();
    chk("wrap_seq_0000", out_seq, 16'h0000);
    chk("wrap_count", count, 1);
    commit_valid = 1'b0;
    tick();
    chk("wrap_empty_count", count, 0);

    // ---------------- halt, ignored commits, drain to done
    do_reset();
    drive(16'h0020, 1'b0);
    tick();
    drive(16'h0022, 1'b0);
    tick();
    drive(16'h0024, 1'b1);
    tick();
    chk("halt_count", count, 3);
    chk("halt_done_early", done, 0);
    for (int i = 0; i < 4; i++) begin
      drive(16'h0030 + 16'(2 * i), 1'b0);
      tick();
    end
    commit_valid = 1'b0;
    chk("drain_ignored_count", count, 3);
    chk("drain_drop_cnt", drop_cnt, 0);
    chk("drain_overflow", overflow, 0);
    chk("drain_done", done, 0);
    out_ready = 1'b1;
    chk("halt_drain_seq0", out_seq, 0);
    tick();
    chk("halt_drain_seq1", out_seq, 1);
    tick();
    chk("halt_last_seq", out_seq, 2);
    chk("halt_last_rec", out_rec, exp_rec(16'h0024, 1'b1));
    chk("halt_bit", out_rec[0], 1);
    chk("halt_done_before_pop", done, 0);
    tick();
    chk("done_set", done, 1);
    chk("done_count", count, 0);
    chk("done_out_valid", out_valid, 0);
    drive(16'h0040, 1'b0);
    repeat (3) tick();
    commit_valid = 1'b0;
    chk("done_sticky", done, 1);
    chk("done_ignored_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
